multicycle_ctrl: RTL and testbench

Multi-cycle sequencer for the 16-bit core. It steps each instruction through FETCH, DECODE, EXEC, MEM and WB states, and shares a single memory port between instruction fetch and data access. It drives the per-cycle datapath enables (PC, IR, register file, memory strobes) and the ALU/operand selects for the core's 4-bit opcode set. It also retires one instruction at a time, so the datapath needs no pipeline registers beyond IR and the ALU/memory output latches.

---
 rtl/multicycle_ctrl_if.sv | 38 +++
 rtl/multicycle_ctrl.sv | 147 ++++++++++++++
 tb/tb_multicycle_ctrl.sv | 162 ++++++++++++++++
 3 files changed

// File: rtl/multicycle_ctrl_if.sv
// Control bundle between the multi-cycle sequencer and the 16-bit core datapath/memory.
// The master modport is the sequencer side; the slave modport is the datapath/environment side.
interface multicycle_ctrl_if;
    logic       run;
    logic [3:0] Opcode;
    logic       zero;
    logic       mem_ack;

    logic       mem_req;
    logic       mem_we;
    logic       mem_addr_sel;
    logic       ir_load;
    logic       pc_write;
    logic [1:0] pc_src;
    logic [1:0] ALUOp;
    logic [1:0] ALUSrc;
    logic       regDst;
    logic       MemtoReg;
    logic       RegWrite;
    logic       instr_done;
    logic       busy;
    logic       fault;
    logic [2:0] state;

    modport master (
        input  run, Opcode, zero, mem_ack,
        output mem_req, mem_we, mem_addr_sel, ir_load, pc_write, pc_src,
               ALUOp, ALUSrc, regDst, MemtoReg, RegWrite, instr_done,
               busy, fault, state
    );

    modport slave (
        output run, Opcode, zero, mem_ack,
        input  mem_req, mem_we, mem_addr_sel, ir_load, pc_write, pc_src,
               ALUOp, ALUSrc, regDst, MemtoReg, RegWrite, instr_done,
               busy, fault, state
    );
endinterface

// File: rtl/multicycle_ctrl.sv
// Multi-cycle FETCH/DECODE/EXEC/MEM/WB sequencer sharing one memory port.
// Handshake: mem_req holds from state entry through the mem_ack cycle; mem_ack is ignored unless mem_req=1.
module multicycle_ctrl #(
    parameter int WAIT_LIMIT = 15
) (
    input  logic                clk,
    input  logic                rst_n,
    multicycle_ctrl_if.master   ctl_if
);
    localparam int CW = (WAIT_LIMIT > 1) ? $clog2(WAIT_LIMIT + 1) : 1;

    localparam logic [2:0] S_IDLE   = 3'b000;
    localparam logic [2:0] S_FETCH  = 3'b001;
    localparam logic [2:0] S_DECODE = 3'b010;
    localparam logic [2:0] S_EXEC   = 3'b011;
    localparam logic [2:0] S_MEM    = 3'b100;
    localparam logic [2:0] S_WB     = 3'b101;
    localparam logic [2:0] S_FAULT  = 3'b111;

    localparam logic [3:0] OP_LW   = 4'b0000;
    localparam logic [3:0] OP_SW   = 4'b0001;
    localparam logic [3:0] OP_ADDI = 4'b0011;
    localparam logic [3:0] OP_BEQ  = 4'b1010;
    localparam logic [3:0] OP_BNE  = 4'b1011;
    localparam logic [3:0] OP_JUMP = 4'b1100;

    logic [2:0]    r_state;
    logic [2:0]    w_next;
    logic [3:0]    r_op_q;
    logic [CW-1:0] r_wait_cnt;
    logic          w_ack;
    logic          w_run;
    logic          w_timeout;
    logic [2:0]    w_boundary;

    assign w_ack      = ctl_if.mem_ack;
    assign w_run      = ctl_if.run;
    assign w_boundary = w_run ? S_FETCH : S_IDLE;
    // Only consulted in FETCH/MEM, where mem_req is always high.
    assign w_timeout  = (WAIT_LIMIT != 0) && (r_wait_cnt == CW'(WAIT_LIMIT)) && !w_ack;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_op_q     <= 4'b0000;
            r_wait_cnt <= '0;
        end else begin
            r_state <= w_next;
            if (r_state == S_DECODE)
                r_op_q <= ctl_if.Opcode;
            // Any state change clears the counter, which covers entry into FETCH and MEM.
            if (w_next != r_state)
                r_wait_cnt <= '0;
            else if (ctl_if.mem_req && !w_ack)
                r_wait_cnt <= r_wait_cnt + CW'(1);
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:   if (w_run) w_next = S_FETCH;
            S_FETCH: begin
                if (w_ack)          w_next = S_DECODE;
                else if (w_timeout) w_next = S_FAULT;
            end
            S_DECODE: w_next = (ctl_if.Opcode > OP_JUMP) ? S_FAULT : S_EXEC;
            S_EXEC: begin
                case (r_op_q)
                    OP_LW, OP_SW:            w_next = S_MEM;
                    OP_BEQ, OP_BNE, OP_JUMP: w_next = w_boundary;
                    4'b0010, OP_ADDI, 4'b0100, 4'b0101, 4'b0110,
                    4'b0111, 4'b1000, 4'b1001: w_next = S_WB;
                    default:                 w_next = S_FAULT;
                endcase
            end
            S_MEM: begin
                if (w_ack)          w_next = (r_op_q == OP_SW) ? w_boundary : S_WB;
                else if (w_timeout) w_next = S_FAULT;
            end
            S_WB:     w_next = w_boundary;
            S_FAULT:  w_next = S_FAULT;
            default:  w_next = S_FAULT;
        endcase
    end

    always_comb begin
        ctl_if.mem_req      = 1'b0;
        ctl_if.mem_we       = 1'b0;
        ctl_if.mem_addr_sel = 1'b0;
        ctl_if.ir_load      = 1'b0;
        ctl_if.pc_write     = 1'b0;
        ctl_if.pc_src       = 2'b00;
        ctl_if.ALUOp        = 2'b00;
        ctl_if.ALUSrc       = 2'b00;
        ctl_if.regDst       = 1'b0;
        ctl_if.MemtoReg     = 1'b0;
        ctl_if.RegWrite     = 1'b0;
        ctl_if.instr_done   = 1'b0;
        ctl_if.busy         = (r_state != S_IDLE) && (r_state != S_FAULT);
        ctl_if.fault        = (r_state == S_FAULT);
        ctl_if.state        = r_state;
        case (r_state)
            S_FETCH: begin
                ctl_if.mem_req  = 1'b1;
                ctl_if.ir_load  = w_ack;
                ctl_if.pc_write = w_ack;
            end
            S_EXEC: begin
                case (r_op_q)
                    OP_LW, OP_SW: begin
                        ctl_if.ALUOp  = 2'b01;
                        ctl_if.ALUSrc = 2'b01;
                    end
                    OP_ADDI: ctl_if.ALUSrc = 2'b10;
                    OP_BEQ, OP_BNE: begin
                        ctl_if.ALUOp      = 2'b10;
                        ctl_if.pc_src     = 2'b01;
                        ctl_if.pc_write   = (r_op_q == OP_BEQ) ? ctl_if.zero : !ctl_if.zero;
                        ctl_if.instr_done = 1'b1;
                    end
                    OP_JUMP: begin
                        ctl_if.pc_src     = 2'b10;
                        ctl_if.pc_write   = 1'b1;
                        ctl_if.instr_done = 1'b1;
                    end
                    default: ;
                endcase
            end
            S_MEM: begin
                ctl_if.mem_req      = 1'b1;
                ctl_if.mem_addr_sel = 1'b1;
                ctl_if.mem_we       = (r_op_q == OP_SW);
                ctl_if.ALUOp        = 2'b01;
                ctl_if.ALUSrc       = 2'b01;
                ctl_if.instr_done   = w_ack && (r_op_q == OP_SW);
            end
            S_WB: begin
                ctl_if.RegWrite   = 1'b1;
                ctl_if.regDst     = (r_op_q != OP_LW) && (r_op_q != OP_ADDI);
                ctl_if.MemtoReg   = (r_op_q == OP_LW);
                ctl_if.instr_done = 1'b1;
            end
            default: ;
        endcase
    end
endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed bench for multicycle_ctrl: inputs change and outputs are checked just after each falling edge.
module tb_multicycle_ctrl;
    logic clk;
    logic rst_n;
    int   pass_cnt;
    int   fail_cnt;
    int   total_cnt;

    multicycle_ctrl_if ifc ();

    multicycle_ctrl #(.WAIT_LIMIT(15)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .ctl_if (ifc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick;
        @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total_cnt++;
        assert (obs === exp) pass_cnt++;
        else begin
            fail_cnt++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] all_outs();
        return {15'd0, ifc.mem_req, ifc.mem_we, ifc.mem_addr_sel, ifc.ir_load, ifc.pc_write,
                ifc.pc_src, ifc.ALUOp, ifc.ALUSrc, ifc.regDst, ifc.MemtoReg, ifc.RegWrite,
                ifc.instr_done, ifc.busy, ifc.fault};
    endfunction

    initial begin
        pass_cnt = 0; fail_cnt = 0; total_cnt = 0;
        rst_n = 1'b0;
        ifc.run = 1'b0; ifc.Opcode = 4'h0; ifc.zero = 1'b0; ifc.mem_ack = 1'b0;

        // Reset and idle
        repeat (3) tick();
        #1 chk("rst_state", ifc.state, 3'b000);
        chk("rst_outs", all_outs(), 32'h0);
        rst_n = 1'b1;
        tick(); #1 chk("idle_hold", ifc.state, 3'b000);
        chk("idle_outs", all_outs(), 32'h0);

        // ADD, zero-wait fetch
        tick(); ifc.run = 1'b1;
        #1 chk("add_pre_idle", ifc.state, 3'b000);
        tick(); ifc.mem_ack = 1'b1;
        #1 chk("add_c1_state", ifc.state, 3'b001);
        chk("add_c1_req", {ifc.mem_req, ifc.mem_addr_sel, ifc.mem_we}, 3'b100);
        chk("add_c1_ir_pc", {ifc.ir_load, ifc.pc_write, ifc.pc_src}, 4'b1100);
        tick(); ifc.mem_ack = 1'b0; ifc.Opcode = 4'h2;
        #1 chk("add_c2_state", ifc.state, 3'b010);
        chk("add_c2_busy", {ifc.busy, ifc.mem_req}, 2'b10);
        tick();
        #1 chk("add_c3_state", ifc.state, 3'b011);
        chk("add_c3_alu", {ifc.ALUOp, ifc.ALUSrc, ifc.instr_done}, 5'b00000);
        tick();
        #1 chk("add_c4_state", ifc.state, 3'b101);
        chk("add_c4_wb", {ifc.RegWrite, ifc.regDst, ifc.MemtoReg, ifc.instr_done}, 4'b1101);

        // LW with three data wait cycles; run drops mid-instruction
        tick(); ifc.mem_ack = 1'b1;
        #1 chk("add_c5_fetch", ifc.state, 3'b001);
        tick(); ifc.mem_ack = 1'b0; ifc.Opcode = 4'h0;
        #1 chk("lw_decode", ifc.state, 3'b010);
        tick(); ifc.Opcode = 4'hE;
        #1 chk("lw_exec_state", ifc.state, 3'b011);
        chk("lw_exec_alu", {ifc.ALUOp, ifc.ALUSrc}, 4'b0101);
        for (int i = 0; i < 3; i++) begin
            tick();
            #1 chk("lw_mem_wait", {ifc.state, ifc.mem_req, ifc.mem_addr_sel, ifc.mem_we}, {3'b100, 3'b110});
        end
        tick(); ifc.mem_ack = 1'b1; ifc.run = 1'b0;
        #1 chk("lw_mem_ack", {ifc.state, ifc.mem_req, ifc.mem_addr_sel, ifc.mem_we, ifc.instr_done}, {3'b100, 4'b1100});
        chk("lw_mem_alu_hold", {ifc.ALUOp, ifc.ALUSrc}, 4'b0101);
        tick(); ifc.mem_ack = 1'b0;
        #1 chk("lw_wb_state", ifc.state, 3'b101);
        chk("lw_wb", {ifc.RegWrite, ifc.regDst, ifc.MemtoReg, ifc.instr_done, ifc.mem_req}, 5'b10110);
        tick();
        #1 chk("lw_halt_idle", {ifc.state, ifc.busy}, 4'b0000);

        // BEQ taken, BNE with zero, JUMP
        tick(); ifc.run = 1'b1;
        tick(); ifc.mem_ack = 1'b1; ifc.Opcode = 4'hA;
        #1 chk("beq_fetch", ifc.state, 3'b001);
        tick(); ifc.mem_ack = 1'b0;
        tick(); ifc.zero = 1'b1;
        #1 chk("beq_exec_state", ifc.state, 3'b011);
        chk("beq_exec", {ifc.pc_write, ifc.pc_src, ifc.ALUOp, ifc.instr_done}, 6'b101101);
        tick(); ifc.mem_ack = 1'b1; ifc.Opcode = 4'hB;
        #1 chk("beq_next_fetch", ifc.state, 3'b001);
        tick(); ifc.mem_ack = 1'b0;
        tick(); ifc.zero = 1'b1;
        #1 chk("bne_z1", {ifc.state, ifc.pc_write, ifc.pc_src, ifc.instr_done}, {3'b011, 4'b0011});
        ifc.zero = 1'b0;
        #1 chk("bne_z0", ifc.pc_write, 1'b1);
        tick(); ifc.mem_ack = 1'b1; ifc.Opcode = 4'hC;
        tick(); ifc.mem_ack = 1'b0;
        tick(); ifc.run = 1'b0;
        #1 chk("jump_exec", {ifc.state, ifc.pc_write, ifc.pc_src, ifc.instr_done}, {3'b011, 4'b1101});
        tick();
        #1 chk("jump_halt_idle", ifc.state, 3'b000);

        // SW zero-wait, then reset asserted during a SW wait
        tick(); ifc.run = 1'b1;
        tick(); ifc.mem_ack = 1'b1; ifc.Opcode = 4'h1;
        tick(); ifc.mem_ack = 1'b0;
        tick();
        #1 chk("sw_exec_alu", {ifc.state, ifc.ALUOp, ifc.ALUSrc}, {3'b011, 4'b0101});
        tick(); ifc.mem_ack = 1'b1;
        #1 chk("sw_mem", {ifc.state, ifc.mem_req, ifc.mem_addr_sel, ifc.mem_we, ifc.instr_done}, {3'b100, 4'b1111});
        tick(); ifc.mem_ack = 1'b1;
        #1 chk("sw_next_fetch", ifc.state, 3'b001);
        tick(); ifc.mem_ack = 1'b0;
        tick();
        tick();
        #1 chk("sw2_mem_wait", {ifc.state, ifc.mem_req, ifc.mem_we}, {3'b100, 2'b11});
        #2 rst_n = 1'b0;
        #1 chk("rst_mid_mem", {ifc.state, all_outs()}, 35'h0);
        tick(); rst_n = 1'b1; ifc.run = 1'b0;
        tick();
        #1 chk("post_rst_idle", ifc.state, 3'b000);
        ifc.run = 1'b1;
        tick();
        #1 chk("post_rst_fetch", {ifc.state, ifc.mem_req}, 4'b0011);

        // Fetch never acked: 16 request cycles then FAULT
        repeat (15) tick();
        #1 chk("to_last_req", {ifc.state, ifc.mem_req}, 4'b0011);
        tick();
        #1 chk("to_fault", {ifc.state, ifc.fault, ifc.mem_req, ifc.busy}, {3'b111, 3'b100});
        tick(); ifc.mem_ack = 1'b1;
        #1 chk("fault_sticky", {ifc.state, all_outs()}, {3'b111, 32'h1});
        rst_n = 1'b0;
        #1 chk("fault_rst", {ifc.state, ifc.fault}, 4'b0000);
        tick(); rst_n = 1'b1; ifc.mem_ack = 1'b0;

        // Ack on the final allowed cycle wins, then illegal opcode faults
        tick();
        #1 chk("lim_fetch", ifc.state, 3'b001);
        repeat (15) tick();
        ifc.mem_ack = 1'b1;
        #1 chk("lim_ack_ir", {ifc.state, ifc.ir_load}, 4'b0011);
        tick(); ifc.mem_ack = 1'b0; ifc.Opcode = 4'hE;
        #1 chk("lim_decode", ifc.state, 3'b010);
        tick();
        #1 chk("illegal_fault", {ifc.state, ifc.fault, ifc.RegWrite}, {3'b111, 2'b10});

        rst_n = 1'b0;
        tick();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
